micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter Direction_BUS_WIDTH, default 11, meaning the control-store address width.
REQ-002 SHALL have parameter COND_BUS_WIDTH, default 3, meaning the MIR COND field width.
REQ-003 SHALL have port MICRO_SEQUENCER_CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port MICRO_SEQUENCER_Reset_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port MICRO_SEQUENCER_COND_In, input, 3 bits: MIR COND field.
REQ-006 SHALL have port MICRO_SEQUENCER_JumpAddr_In, input, 11 bits: MIR JUMP ADDR field.
REQ-007 SHALL have port MICRO_SEQUENCER_RD_In, input, 1 bit: MIR memory-read request.
REQ-008 SHALL have port MICRO_SEQUENCER_WR_In, input, 1 bit: MIR memory-write request.
REQ-009 SHALL have ports MICRO_SEQUENCER_PSR_Negative_In, _Zero_In, _Overflow_In, _Carry_In, input, 1 bit each: registered PSR flags.
REQ-010 SHALL have ports MICRO_SEQUENCER_RegIR_OP_In (2 bits), _RegIR_OP3_In (6 bits), _RegIR_BIT13_In (1 bit), input: IR fields.
REQ-011 SHALL have port MICRO_SEQUENCER_MemAck_In, input, 1 bit: memory completion acknowledge.
REQ-012 SHALL have port MICRO_SEQUENCER_CSAddress_Out, output, 11 bits: control-store address (CSAR).
REQ-013 SHALL have port MICRO_SEQUENCER_MIRLoad_Out, output, 1 bit: MIR loads the control-store word this cycle.
REQ-014 SHALL have port MICRO_SEQUENCER_MemReq_Out, output, 1 bit: memory access in progress.
REQ-015 SHALL have ports MICRO_SEQUENCER_State_Out, output, 2 bits (IDLE=00, RUN=01, MEMWAIT=10), and MICRO_SEQUENCER_Error_Out, output, 1 bit: sticky illegal-MIR flag.

Function
REQ-016 SHALL hold CSAR register; CSAddress_Out SHALL equal CSAR combinationally.
REQ-017 SHALL compute next address by COND: 000 CSAR+1; 001 JumpAddr if N else CSAR+1; 010 same on Z; 011 on V; 100 on C; 101 on BIT13; 110 JumpAddr unconditionally; 111 decode address {1'b1, OP[1:0], OP3[5:0], 2'b00}.
REQ-018 SHALL wrap CSAR+1 modulo 2^11 (0x7FF -> 0x000).
REQ-019 SHALL implement FSM IDLE, RUN, MEMWAIT.
REQ-020 IDLE: SHALL hold CSAR=0, MIRLoad_Out=1, and go to RUN next cycle unconditionally.
REQ-021 RUN, RD xor WR high: SHALL hold CSAR, go to MEMWAIT, assert MemReq_Out from the next cycle.
REQ-022 RUN, RD=WR=0: SHALL load CSAR with next address every cycle, MIRLoad_Out=1.
REQ-023 RUN, RD=WR=1: SHALL set Error_Out (sticky until reset), perform no memory access, advance as REQ-022.
REQ-024 MEMWAIT: SHALL keep MemReq_Out=1, MIRLoad_Out=0, CSAR held while MemAck_In=0.
REQ-025 MEMWAIT with MemAck_In=1: SHALL load CSAR with next address evaluated from that cycle's inputs, drop MemReq_Out next cycle, pulse MIRLoad_Out, return to RUN.
REQ-026 MemAck_In SHALL be ignored outside MEMWAIT; no request latency shorter than one cycle.
REQ-027 Branch-not-taken cost SHALL equal taken cost: one cycle per micro-instruction outside MEMWAIT.

Reset
REQ-028 Reset low SHALL force, without a clock: CSAR=0x000, State=IDLE, MemReq_Out=0, MIRLoad_Out=1, Error_Out=0.
REQ-029 Reset asserted in MEMWAIT SHALL abandon the access immediately (MemReq_Out=0); first post-reset fetch from 0x000.

Verification
REQ-030 Release reset, COND=000, RD=WR=0 -> CSAddress 0x000 (IDLE), then 0x000, 0x001, 0x002 successive cycles, State 00 then 01.
REQ-031 CSAR=0x010, COND=010, JumpAddr=0x123: Z=1 -> 0x123; Z=0 -> 0x011; repeat COND=110 with Z=0 -> 0x123.
REQ-032 COND=111, OP=2'b10, OP3=6'b000001 -> CSAddress 0x604; OP=2'b11, OP3=6'b000000 -> 0x700.
REQ-033 RD=1 at CSAR=0x050, MemAck_In low 3 cycles then high -> CSAR holds 0x050, MemReq_Out high 4 cycles, CSAR=0x051 after ack, State 10 then 01.
REQ-034 CSAR=0x7FF, COND=000 -> 0x000; RD=WR=1 -> Error_Out=1, no MemReq_Out, remains 1 until reset.
REQ-035 Reset low mid-MEMWAIT -> MemReq_Out=0, CSAddress=0x000, State=00 asynchronously, Error_Out cleared.

Source files
------------

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Purpose:
//    Microprogram sequencer for a microcoded CPU. It holds the control-store
//    address register (CSAR) and chooses the next micro-address from the MIR
//    COND field:
//    - sequential (+1)
//    - conditional jump on a PSR flag or IR bit 13
//    - unconditional jump
//    - opcode decode dispatch
//    A small FSM (IDLE / RUN / MEMWAIT) stalls the sequencer while a memory
//    access requested by the MIR is outstanding.
//
// Ports:
//    MICRO_SEQUENCER_CLOCK_50          in   clock, rising-edge
//    MICRO_SEQUENCER_Reset_InLow       in   asynchronous active-low reset
//    MICRO_SEQUENCER_COND_In           in   MIR COND field
//    MICRO_SEQUENCER_JumpAddr_In       in   MIR JUMP ADDR field
//    MICRO_SEQUENCER_RD_In / _WR_In    in   MIR memory read / write request
//    MICRO_SEQUENCER_PSR_*_In          in   registered PSR flags N, Z, V, C
//    MICRO_SEQUENCER_RegIR_OP_In       in   IR op    (2 bits)
//    MICRO_SEQUENCER_RegIR_OP3_In      in   IR op3   (6 bits)
//    MICRO_SEQUENCER_RegIR_BIT13_In    in   IR bit 13
//    MICRO_SEQUENCER_MemAck_In         in   memory completion acknowledge
//    MICRO_SEQUENCER_CSAddress_Out     out  control-store address (= CSAR)
//    MICRO_SEQUENCER_MIRLoad_Out       out  MIR loads control-store word now
//    MICRO_SEQUENCER_MemReq_Out        out  memory access in progress
//    MICRO_SEQUENCER_State_Out         out  FSM state (IDLE=00 RUN=01 MEMWAIT=10)
//    MICRO_SEQUENCER_Error_Out         out  sticky illegal-MIR (RD and WR) flag
// -----------------------------------------------------------------------------
module micro_sequencer #(
   parameter int Direction_BUS_WIDTH = 11,
   parameter int COND_BUS_WIDTH      = 3
) (
   input  logic                           MICRO_SEQUENCER_CLOCK_50,
   input  logic                           MICRO_SEQUENCER_Reset_InLow,
   input  logic [COND_BUS_WIDTH-1:0]      MICRO_SEQUENCER_COND_In,
   input  logic [Direction_BUS_WIDTH-1:0] MICRO_SEQUENCER_JumpAddr_In,
   input  logic                           MICRO_SEQUENCER_RD_In,
   input  logic                           MICRO_SEQUENCER_WR_In,
   input  logic                           MICRO_SEQUENCER_PSR_Negative_In,
   input  logic                           MICRO_SEQUENCER_PSR_Zero_In,
   input  logic                           MICRO_SEQUENCER_PSR_Overflow_In,
   input  logic                           MICRO_SEQUENCER_PSR_Carry_In,
   input  logic [1:0]                     MICRO_SEQUENCER_RegIR_OP_In,
   input  logic [5:0]                     MICRO_SEQUENCER_RegIR_OP3_In,
   input  logic                           MICRO_SEQUENCER_RegIR_BIT13_In,
   input  logic                           MICRO_SEQUENCER_MemAck_In,
   output logic [Direction_BUS_WIDTH-1:0] MICRO_SEQUENCER_CSAddress_Out,
   output logic                           MICRO_SEQUENCER_MIRLoad_Out,
   output logic                           MICRO_SEQUENCER_MemReq_Out,
   output logic [1:0]                     MICRO_SEQUENCER_State_Out,
   output logic                           MICRO_SEQUENCER_Error_Out
);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_RUN     = 2'b01;
   localparam logic [1:0] ST_MEMWAIT = 2'b10;

   logic [1:0]                     r_state;
   logic [Direction_BUS_WIDTH-1:0] r_csar;
   logic                           r_error;

   logic                           w_take_jump;
   logic                           w_mem_single;
   logic                           w_mem_illegal;
   logic [10:0]                    w_decode_raw;
   logic [Direction_BUS_WIDTH-1:0] w_decode_addr;
   logic [Direction_BUS_WIDTH-1:0] w_csar_inc;
   logic [Direction_BUS_WIDTH-1:0] w_next_addr;

   // Exactly one of RD/WR starts an access; both together is an illegal MIR
   // that is flagged and otherwise treated as a plain sequencing step.
   assign w_mem_single  = MICRO_SEQUENCER_RD_In ^ MICRO_SEQUENCER_WR_In;
   assign w_mem_illegal = MICRO_SEQUENCER_RD_In & MICRO_SEQUENCER_WR_In;

   // Opcode dispatch: each op/op3 pair owns a 4-word slot in the upper half
   // of the control store.
   assign w_decode_raw  = {1'b1, MICRO_SEQUENCER_RegIR_OP_In,
                           MICRO_SEQUENCER_RegIR_OP3_In, 2'b00};
   assign w_decode_addr = Direction_BUS_WIDTH'(w_decode_raw);

   // Natural wrap at the top of the control store.
   assign w_csar_inc = r_csar + 1'b1;

   always_comb begin
      w_take_jump = 1'b0;
      case (MICRO_SEQUENCER_COND_In)
         3'b001:  w_take_jump = MICRO_SEQUENCER_PSR_Negative_In;
         3'b010:  w_take_jump = MICRO_SEQUENCER_PSR_Zero_In;
         3'b011:  w_take_jump = MICRO_SEQUENCER_PSR_Overflow_In;
         3'b100:  w_take_jump = MICRO_SEQUENCER_PSR_Carry_In;
         3'b101:  w_take_jump = MICRO_SEQUENCER_RegIR_BIT13_In;
         3'b110:  w_take_jump = 1'b1;
         default: w_take_jump = 1'b0;
      endcase
   end

   always_comb begin
      if (MICRO_SEQUENCER_COND_In == 3'b111) begin
         w_next_addr = w_decode_addr;
      end else if (w_take_jump) begin
         w_next_addr = MICRO_SEQUENCER_JumpAddr_In;
      end else begin
         w_next_addr = w_csar_inc;
      end
   end

   always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_Reset_InLow) begin
      if (!MICRO_SEQUENCER_Reset_InLow) begin
         r_state <= ST_IDLE;
         r_csar  <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_csar  <= '0;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_mem_single) begin
                  // CSAR holds so the MIR keeps the access micro-instruction.
                  r_state <= ST_MEMWAIT;
               end else begin
                  r_csar <= w_next_addr;
                  if (w_mem_illegal) begin
                     r_error <= 1'b1;
                  end
               end
            end
            ST_MEMWAIT: begin
               if (MICRO_SEQUENCER_MemAck_In) begin
                  r_csar  <= w_next_addr;
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_csar  <= '0;
            end
         endcase
      end
   end

   // MemReq is exactly "in MEMWAIT", so it rises the cycle after the request
   // and vanishes asynchronously with reset.
   assign MICRO_SEQUENCER_MemReq_Out    = (r_state == ST_MEMWAIT);
   assign MICRO_SEQUENCER_CSAddress_Out = r_csar;
   assign MICRO_SEQUENCER_State_Out     = r_state;
   assign MICRO_SEQUENCER_Error_Out     = r_error;

   always_comb begin
      case (r_state)
         ST_RUN:     MICRO_SEQUENCER_MIRLoad_Out = ~w_mem_single;
         ST_MEMWAIT: MICRO_SEQUENCER_MIRLoad_Out = MICRO_SEQUENCER_MemAck_In;
         default:    MICRO_SEQUENCER_MIRLoad_Out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//
// Purpose:
//    Directed, table-driven bench for micro_sequencer. Each vector gives the
//    MIR/flag/IR inputs of one cycle. It also gives:
//    - the expected MIRLoad before the clock edge
//    - the expected CSAR, state, MemReq and Error after the clock edge
//    Hand-written sequences cover reset and reset abandoning a memory access.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

   logic        clk;
   logic        rst_n;
   logic [2:0]  cond;
   logic [10:0] jump;
   logic        rd, wr, fn, fz, fv, fc, b13, ack;
   logic [1:0]  op;
   logic [5:0]  op3;
   logic [10:0] cs_addr;
   logic        mir_load, mem_req, err;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  cond;
      logic [10:0] jump;
      logic [3:0]  nzvc;
      logic        b13;
      logic [1:0]  op;
      logic [5:0]  op3;
      logic        rd, wr, ack;
      logic        exp_mir;
      logic [10:0] exp_csar;
      logic [1:0]  exp_state;
      logic        exp_req;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 31;
   vec_t vecs[NVEC];

   micro_sequencer dut (
      .MICRO_SEQUENCER_CLOCK_50        (clk),
      .MICRO_SEQUENCER_Reset_InLow     (rst_n),
      .MICRO_SEQUENCER_COND_In         (cond),
      .MICRO_SEQUENCER_JumpAddr_In     (jump),
      .MICRO_SEQUENCER_RD_In           (rd),
      .MICRO_SEQUENCER_WR_In           (wr),
      .MICRO_SEQUENCER_PSR_Negative_In (fn),
      .MICRO_SEQUENCER_PSR_Zero_In     (fz),
      .MICRO_SEQUENCER_PSR_Overflow_In (fv),
      .MICRO_SEQUENCER_PSR_Carry_In    (fc),
      .MICRO_SEQUENCER_RegIR_OP_In     (op),
      .MICRO_SEQUENCER_RegIR_OP3_In    (op3),
      .MICRO_SEQUENCER_RegIR_BIT13_In  (b13),
      .MICRO_SEQUENCER_MemAck_In       (ack),
      .MICRO_SEQUENCER_CSAddress_Out   (cs_addr),
      .MICRO_SEQUENCER_MIRLoad_Out     (mir_load),
      .MICRO_SEQUENCER_MemReq_Out      (mem_req),
      .MICRO_SEQUENCER_State_Out       (state),
      .MICRO_SEQUENCER_Error_Out       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] c, input logic [10:0] j, input logic [3:0] nzvc,
                               input logic bit13, input logic [1:0] o, input logic [5:0] o3,
                               input logic r, input logic w, input logic a, input logic mir,
                               input logic [10:0] csar, input logic [1:0] st,
                               input logic req, input logic e);
      vec_t v;
      v.cond = c; v.jump = j; v.nzvc = nzvc; v.b13 = bit13; v.op = o; v.op3 = o3;
      v.rd = r; v.wr = w; v.ack = a; v.exp_mir = mir; v.exp_csar = csar;
      v.exp_state = st; v.exp_req = req; v.exp_err = e;
      return v;
   endfunction

   task automatic drive_idle();
      cond = 3'b000; jump = '0; rd = 0; wr = 0; fn = 0; fz = 0; fv = 0; fc = 0;
      b13 = 0; op = '0; op3 = '0; ack = 0;
   endtask

   initial begin
      // Table: cond, jump, nzvc, b13, op, op3, rd, wr, ack |
      //        mir(pre-edge), csar, state, memreq, error (post-edge)
      vecs[0]  = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h000, 2'b01, 0, 0);
      vecs[1]  = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h001, 2'b01, 0, 0);
      vecs[2]  = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h002, 2'b01, 0, 0);
      vecs[3]  = mk(3'b110, 11'h010, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h010, 2'b01, 0, 0);
      vecs[4]  = mk(3'b010, 11'h123, 4'b0100, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h123, 2'b01, 0, 0);
      vecs[5]  = mk(3'b110, 11'h010, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h010, 2'b01, 0, 0);
      vecs[6]  = mk(3'b010, 11'h123, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h011, 2'b01, 0, 0);
      vecs[7]  = mk(3'b110, 11'h123, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h123, 2'b01, 0, 0);
      vecs[8]  = mk(3'b001, 11'h200, 4'b1000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h200, 2'b01, 0, 0);
      vecs[9]  = mk(3'b001, 11'h200, 4'b0111, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h201, 2'b01, 0, 0);
      vecs[10] = mk(3'b011, 11'h300, 4'b0010, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h300, 2'b01, 0, 0);
      vecs[11] = mk(3'b100, 11'h0AA, 4'b0001, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h0AA, 2'b01, 0, 0);
      vecs[12] = mk(3'b100, 11'h0AA, 4'b1110, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h0AB, 2'b01, 0, 0);
      vecs[13] = mk(3'b101, 11'h155, 4'b0000, 1, 2'b00, 6'h00, 0, 0, 0, 1, 11'h155, 2'b01, 0, 0);
      vecs[14] = mk(3'b101, 11'h155, 4'b1111, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h156, 2'b01, 0, 0);
      vecs[15] = mk(3'b011, 11'h300, 4'b1101, 1, 2'b00, 6'h00, 0, 0, 0, 1, 11'h157, 2'b01, 0, 0);
      vecs[16] = mk(3'b111, 11'h000, 4'b0000, 0, 2'b10, 6'h01, 0, 0, 0, 1, 11'h604, 2'b01, 0, 0);
      vecs[17] = mk(3'b111, 11'h000, 4'b0000, 0, 2'b11, 6'h00, 0, 0, 0, 1, 11'h700, 2'b01, 0, 0);
      vecs[18] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 1, 1, 11'h701, 2'b01, 0, 0);
      vecs[19] = mk(3'b110, 11'h050, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h050, 2'b01, 0, 0);
      // Read at 0x050: three wait cycles, then ack
      vecs[20] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 0, 0, 11'h050, 2'b10, 1, 0);
      vecs[21] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 0, 0, 11'h050, 2'b10, 1, 0);
      vecs[22] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 0, 0, 11'h050, 2'b10, 1, 0);
      vecs[23] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 0, 0, 11'h050, 2'b10, 1, 0);
      vecs[24] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 0, 1, 1, 11'h051, 2'b01, 0, 0);
      // Write whose ack cycle carries a jump to the top of the store
      vecs[25] = mk(3'b110, 11'h7FF, 4'b0000, 0, 2'b00, 6'h00, 0, 1, 0, 0, 11'h051, 2'b10, 1, 0);
      vecs[26] = mk(3'b110, 11'h7FF, 4'b0000, 0, 2'b00, 6'h00, 0, 1, 1, 1, 11'h7FF, 2'b01, 0, 0);
      vecs[27] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h000, 2'b01, 0, 0);
      vecs[28] = mk(3'b110, 11'h7FF, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h7FF, 2'b01, 0, 0);
      // Illegal RD+WR: advances, no access, sticky error
      vecs[29] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 1, 1, 0, 1, 11'h000, 2'b01, 0, 1);
      vecs[30] = mk(3'b000, 11'h000, 4'b0000, 0, 2'b00, 6'h00, 0, 0, 0, 1, 11'h001, 2'b01, 0, 1);

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_csar",  32'(cs_addr),  32'h000);
      chk("rst_state", 32'(state),    32'h0);
      chk("rst_req",   32'(mem_req),  32'h0);
      chk("rst_mir",   32'(mir_load), 32'h1);
      chk("rst_err",   32'(err),      32'h0);

      rst_n = 1'b1;
      #1;
      chk("idle_csar",  32'(cs_addr), 32'h000);
      chk("idle_state", 32'(state),   32'h0);

      for (int i = 0; i < NVEC; i++) begin
         cond = vecs[i].cond; jump = vecs[i].jump;
         {fn, fz, fv, fc} = vecs[i].nzvc;
         b13 = vecs[i].b13; op = vecs[i].op; op3 = vecs[i].op3;
         rd = vecs[i].rd; wr = vecs[i].wr; ack = vecs[i].ack;
         #1;
         chk($sformatf("v%0d_mir", i), 32'(mir_load), 32'(vecs[i].exp_mir));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_csar", i),  32'(cs_addr), 32'(vecs[i].exp_csar));
         chk($sformatf("v%0d_state", i), 32'(state),   32'(vecs[i].exp_state));
         chk($sformatf("v%0d_req", i),   32'(mem_req), 32'(vecs[i].exp_req));
         chk($sformatf("v%0d_err", i),   32'(err),     32'(vecs[i].exp_err));
         $display("vec %0d: cond=%b jump=%03h rd=%b wr=%b ack=%b -> csar=%03h state=%b req=%b err=%b",
                  i, cond, jump, rd, wr, ack, cs_addr, state, mem_req, err);
      end

      // Enter MEMWAIT, then pull reset mid-cycle with no clock edge
      drive_idle();
      rd = 1'b1;
      @(posedge clk);
      #1;
      chk("mw_state", 32'(state),   32'h2);
      chk("mw_req",   32'(mem_req), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req",   32'(mem_req),  32'h0);
      chk("arst_csar",  32'(cs_addr),  32'h000);
      chk("arst_state", 32'(state),    32'h0);
      chk("arst_err",   32'(err),      32'h0);
      chk("arst_mir",   32'(mir_load), 32'h1);
      $display("async reset in MEMWAIT: csar=%03h state=%b req=%b err=%b", cs_addr, state, mem_req, err);

      // Reset held across an edge keeps the state in IDLE
      @(posedge clk);
      #1;
      chk("hold_state", 32'(state), 32'h0);
      drive_idle();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_csar0",  32'(cs_addr), 32'h000);
      chk("post_state0", 32'(state),   32'h1);
      @(posedge clk);
      #1;
      chk("post_csar1",  32'(cs_addr), 32'h001);
      chk("post_err",    32'(err),     32'h0);
      $display("post-reset fetch: csar=%03h state=%b", cs_addr, state);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
